// File: rtl/ringbuffer_drain.sv
// Drains a ringbuffer: fetches the entry at read_addr from the buffer RAM, streams it
// MSB-first as bytes over a valid/ready interface, optionally appends a terminator, then retires it.
module ringbuffer_drain #(
  parameter int         BITS       = 4,
  parameter int         DATA_WIDTH = 32,
  parameter int         TERM_EN    = 1,
  parameter logic [7:0] TERM_BYTE  = 8'h0a
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [BITS-1:0]       read_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  read_done,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, SEND, TERM, DONE, SETTLE
  } state_e;

  localparam state_e AFTER_LAST = (TERM_EN != 0) ? TERM : DONE;

  state_e                state, next_state;
  logic [DATA_WIDTH-1:0] latch;
  logic [DATA_WIDTH-1:0] shifted;
  logic [CW-1:0]         byte_cnt;
  logic                  accept;

  // read_addr is wired to the RAM outside this block; it is only carried here for interface symmetry.
  logic unused_read_addr;
  assign unused_read_addr = ^read_addr;

  assign accept  = tx_valid & tx_ready;
  assign shifted = latch << 8;

  assign rd_en     = (state == FETCH);
  assign read_done = (state == DONE);
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state gets its default first, so no path through the case can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (!empty) next_state = FETCH;
      FETCH:   next_state = LATCH;
      LATCH:   next_state = SEND;
      SEND:    if (accept && byte_cnt == '0) next_state = AFTER_LAST;
      TERM:    if (accept) next_state = DONE;
      DONE:    next_state = SETTLE;
      SETTLE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Byte datapath; tx_data/tx_valid only move on acceptance, so a stalled byte is held intact.
  always_ff @(posedge clk) begin
    if (!reset) begin
      latch    <= '0;
      byte_cnt <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      unique case (state)
        LATCH: begin
          latch    <= rd_data;
          byte_cnt <= CW'(BYTES - 1);
          tx_data  <= rd_data[DATA_WIDTH-1 -: 8];
          tx_valid <= 1'b1;
        end
        SEND: begin
          if (accept) begin
            if (byte_cnt == '0) begin
              if (TERM_EN != 0) tx_data  <= TERM_BYTE;
              else              tx_valid <= 1'b0;
            end else begin
              latch    <= shifted;
              tx_data  <= shifted[DATA_WIDTH-1 -: 8];
              byte_cnt <= byte_cnt - 1'b1;
            end
          end
        end
        TERM: begin
          if (accept) tx_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ringbuffer_drain.sv
// Bench for ringbuffer_drain: a small ring + RAM model feeds a 32-bit/terminator instance,
// a fixed one-entry source feeds a 16-bit/no-terminator instance; accepted bytes are scoreboarded.
module tb_ringbuffer_drain;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance with terminator
  logic        empty;
  logic [3:0]  read_addr;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        read_done;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;

  // 16-bit instance without terminator
  logic        empty16;
  logic [3:0]  read_addr16 = 4'd0;
  logic        rd_en16;
  logic [15:0] rd_data16;
  logic        read_done16;
  logic [7:0]  tx_data16;
  logic        tx_valid16;
  logic        busy16;

  ringbuffer_drain #(.BITS(4), .DATA_WIDTH(32), .TERM_EN(1), .TERM_BYTE(8'h0a)) dut (
    .clk(clk), .reset(rst_n), .empty(empty), .read_addr(read_addr), .rd_en(rd_en),
    .rd_data(rd_data), .read_done(read_done), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy)
  );

  ringbuffer_drain #(.BITS(4), .DATA_WIDTH(16), .TERM_EN(0), .TERM_BYTE(8'h0a)) dut16 (
    .clk(clk), .reset(rst_n), .empty(empty16), .read_addr(read_addr16), .rd_en(rd_en16),
    .rd_data(rd_data16), .read_done(read_done16), .tx_data(tx_data16), .tx_valid(tx_valid16),
    .tx_ready(tx_ready), .busy(busy16)
  );

  // Ringbuffer + registered-read RAM model
  logic [31:0] ring_mem [16];
  logic [3:0]  wr_ptr, rd_ptr;
  logic [4:0]  fill;
  logic        wr_req = 1'b0;
  logic [31:0] wr_val = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (wr_req) begin
        ring_mem[wr_ptr] <= wr_val;
        wr_ptr <= wr_ptr + 4'd1;
      end
      if (read_done) rd_ptr <= rd_ptr + 4'd1;
      fill <= fill + 5'(wr_req) - 5'(read_done);
    end
    if (rd_en) rd_data <= ring_mem[read_addr];
  end
  assign empty     = (fill == 5'd0);
  assign read_addr = rd_ptr;

  // Single-entry source for the 16-bit instance
  logic start16 = 1'b0;
  always @(posedge clk) begin
    if (!rst_n)           empty16 <= 1'b1;
    else if (start16)     empty16 <= 1'b0;
    else if (read_done16) empty16 <= 1'b1;
    if (rd_en16) rd_data16 <= 16'hA55A;
  end

  int cyc = 0;
  int ready_period = 1;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    tx_ready = (ready_period <= 1) || (cyc % ready_period == 0);
  end

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor, sampled on the falling edge
  logic [7:0] q   [$];
  logic [7:0] q16 [$];
  int done_cnt = 0, rden_cnt = 0, done16_cnt = 0;
  int fall_cyc = 0, valid_cyc = 0, acc16_cyc = 0, done16_cyc = 0;
  logic empty_q = 1'b1, valid_q = 1'b0, stall_q = 1'b0;
  logic [7:0] stall_data = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_q) begin
        check("stall_hold_valid", tx_valid, 1);
        check("stall_hold_data", tx_data, stall_data);
      end
      if (tx_valid && tx_ready) q.push_back(tx_data);
      if (read_done) done_cnt++;
      if (rd_en) rden_cnt++;
      if (empty_q && !empty) fall_cyc = cyc;
      if (!valid_q && tx_valid) valid_cyc = cyc;
      if (tx_valid16 && tx_ready) begin
        q16.push_back(tx_data16);
        acc16_cyc = cyc;
      end
      if (read_done16) begin
        done16_cnt++;
        done16_cyc = cyc;
      end
    end
    stall_q    = rst_n && tx_valid && !tx_ready;
    stall_data = tx_data;
    empty_q    = empty;
    valid_q    = tx_valid;
  end

  task automatic push(input logic [31:0] v);
    @(posedge clk); #1;
    wr_req = 1'b1;
    wr_val = v;
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, done_cnt, target);
  endtask

  task automatic check_frame(input logic [7:0] exp [5]);
    logic [7:0] got;
    check("frame_len", q.size(), 5);
    for (int b = 0; b < 5; b++) begin
      got = (b < q.size()) ? q[b] : 8'hxx;
      check("frame_byte", got, exp[b]);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          period;
    logic [7:0]  exp [5];
  } vec_t;

  vec_t vecs [4];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int d0, r0, n;
    logic [7:0] got, expb;

    vecs[0] = '{32'hDEADBEEF, 1, '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0A}};
    vecs[1] = '{32'hDEADBEEF, 3, '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0A}};
    vecs[2] = '{32'h11223344, 1, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0A}};
    vecs[3] = '{32'h80FF0001, 2, '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h0A}};

    // Reset held, then idle with an empty ring
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_rd_en", rd_en, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_read_done", read_done, 0);
      check("rst_busy", busy, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_rd_en", rd_en, 0);
      check("idle_tx_valid", tx_valid, 0);
      check("idle_read_done", read_done, 0);
      check("idle_busy", busy, 0);
    end

    // Table-driven single entries with various ready patterns
    for (int i = 0; i < 4; i++) begin
      ready_period = vecs[i].period;
      q.delete();
      d0 = done_cnt;
      r0 = rden_cnt;
      push(vecs[i].data);
      wait_done(d0 + 1, 200, "read_done_arrival");
      repeat (3) @(posedge clk);
      #1;
      check_frame(vecs[i].exp);
      check("read_done_once", done_cnt - d0, 1);
      check("rd_en_once", rden_cnt - r0, 1);
      check("first_valid_latency", valid_cyc - fall_cyc, 3);
      check("idle_after_entry", busy, 0);
    end

    // Reset while byte 2 is on the wire: entry abandoned, then re-sent whole
    ready_period = 1;
    q.delete();
    d0 = done_cnt;
    push(32'h11223344);
    n = 0;
    while (!(tx_valid && tx_data == 8'h22) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reached_byte2", tx_data, 8'h22);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("no_done_before_reset", done_cnt - d0, 0);
    check("reset_tx_valid", tx_valid, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    q.delete();
    d0 = done_cnt;
    push(32'h11223344);
    wait_done(d0 + 1, 200, "resend_read_done");
    repeat (3) @(posedge clk);
    #1;
    check_frame(vecs[2].exp);

    // Full ring of 16 entries, pointer wraps back to 0
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    d0 = done_cnt;
    for (int i = 0; i < 16; i++) push(32'(i));
    wait_done(d0 + 16, 800, "ring_all_done");
    repeat (3) @(posedge clk);
    #1;
    check("ring_byte_total", q.size(), 80);
    for (int i = 0; i < 16; i++) begin
      for (int b = 0; b < 5; b++) begin
        expb = (b == 3) ? 8'(i) : (b == 4) ? 8'h0A : 8'h00;
        got  = (i * 5 + b < q.size()) ? q[i * 5 + b] : 8'hxx;
        check("ring_byte", got, expb);
      end
    end
    check("ring_empty_end", empty, 1);
    check("ring_read_addr_wrap", read_addr, 0);

    // 16-bit entry, no terminator
    ready_period = 1;
    q16.delete();
    @(posedge clk); #1;
    start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    n = 0;
    while (done16_cnt < 1 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("w16_read_done_once", done16_cnt, 1);
    check("w16_len", q16.size(), 2);
    got = (q16.size() > 0) ? q16[0] : 8'hxx;
    check("w16_byte0", got, 8'hA5);
    got = (q16.size() > 1) ? q16[1] : 8'hxx;
    check("w16_byte1", got, 8'h5A);
    check("w16_done_after_last", done16_cyc - acc16_cyc, 1);
    check("w16_idle", busy16, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
